// File: rtl/vga_con_pkg.sv
// Shared types and constants for the VGA console controller and its FIFO.
package vga_con_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLEAR
    } con_state_e;

    localparam logic [4:0] OFF_DATA   = 5'h00;
    localparam logic [4:0] OFF_CURSOR = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h18;

    localparam logic [7:0] CH_BS        = 8'h08;
    localparam logic [7:0] CH_LF        = 8'h0A;
    localparam logic [7:0] CH_FF        = 8'h0C;
    localparam logic [7:0] FILL_DEFAULT = 8'h20;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_con_fifo.sv
// Synchronous putchar FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module vga_con_fifo
    import vga_con_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_console_ctrl.sv
// Memory-mapped console controller owning the VGA text-buffer write port.
// Optional: define VGA_CON_BACKSPACE_EN to make 0x08 erase the previous cell.
module vga_console_ctrl
    import vga_con_pkg::*;
#(
    parameter int unsigned CHARS      = 36,
    parameter int unsigned COLS       = 18,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [63:0] BASE_ADDR  = 64'h0b000100
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic        cpu_ready,
    output logic [63:0] cpu_rdata,
    output logic        buf_we,
    output logic [5:0]  buf_addr,
    output logic [7:0]  buf_wdata
);

    con_state_e  state, state_n;
    logic [5:0]  cursor, cursor_n;
    logic [7:0]  fill, fill_n;
    logic [6:0]  clr_idx, clr_idx_n;
    logic        ff_pend, ff_pend_n;
    logic        we_n;
    logic [5:0]  addr_n;
    logic [7:0]  wdata_n;

    logic        in_win;
    logic [4:0]  off;
    logic        wr_hit;
    logic        wr_acc;
    logic        rd_acc;
    logic        busy;
    logic [63:0] status;

    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    logic [5:0]  cur_clamp;
    logic [5:0]  cur_inc;
    logic [31:0] nl_pos;
    logic [5:0]  nl_cur;
`ifdef VGA_CON_BACKSPACE_EN
    logic [5:0]  bs_cur;
    assign bs_cur = (cursor == '0) ? '0 : cursor - 6'd1;
`endif

    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata[63:16];

    assign in_win = (cpu_addr >= BASE_ADDR) && (cpu_addr < BASE_ADDR + 64'h20);
    assign off    = cpu_addr[4:0] - BASE_ADDR[4:0];
    assign busy   = (state != ST_IDLE) || !fifo_empty;
    assign wr_hit = cpu_we && in_win;

    always_comb begin
        cpu_ready = 1'b1;
        if (wr_hit && off == OFF_DATA && fifo_full) begin
            cpu_ready = 1'b0;
        end
        if (wr_hit && (off == OFF_CURSOR || off == OFF_CTRL) && busy) begin
            cpu_ready = 1'b0;
        end
    end

    assign wr_acc    = wr_hit && cpu_ready;
    assign rd_acc    = cpu_re && in_win && cpu_ready;
    assign fifo_push = wr_acc && (off == OFF_DATA);

    assign cur_clamp = (32'(cpu_wdata[5:0]) >= CHARS) ? 6'(CHARS - 1) : cpu_wdata[5:0];
    assign cur_inc   = (32'(cursor) == CHARS - 1) ? '0 : cursor + 6'd1;
    assign nl_pos    = (32'(cursor) / COLS + 32'd1) * COLS;
    assign nl_cur    = (nl_pos >= CHARS) ? '0 : 6'(nl_pos);

    always_comb begin
        status        = '0;
        status[0]     = busy;
        status[1]     = fifo_full;
        status[13:8]  = cursor;
        status[23:16] = fill;
    end

    vga_con_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (fifo_push),
        .push_data (cpu_wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The character is decoded on the pop edge so the registered buf write
    // lands in the PUT cycle; PUT only decides between IDLE and CLEAR.
    always_comb begin
        state_n   = state;
        cursor_n  = cursor;
        fill_n    = fill;
        clr_idx_n = clr_idx;
        ff_pend_n = ff_pend;
        we_n      = 1'b0;
        addr_n    = buf_addr;
        wdata_n   = buf_wdata;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_n   = ST_PUT;
                    ff_pend_n = (fifo_dout == CH_FF);
                    if (is_printable(fifo_dout)) begin
                        we_n     = 1'b1;
                        addr_n   = cursor;
                        wdata_n  = fifo_dout;
                        cursor_n = cur_inc;
                    end else if (fifo_dout == CH_LF) begin
                        cursor_n = nl_cur;
                    end
`ifdef VGA_CON_BACKSPACE_EN
                    else if (fifo_dout == CH_BS) begin
                        we_n     = 1'b1;
                        addr_n   = bs_cur;
                        wdata_n  = fill;
                        cursor_n = bs_cur;
                    end
`endif
                end else if (wr_acc && off == OFF_CURSOR) begin
                    cursor_n = cur_clamp;
                end else if (wr_acc && off == OFF_CTRL) begin
                    fill_n = cpu_wdata[15:8];
                    if (cpu_wdata[0]) begin
                        state_n   = ST_CLEAR;
                        clr_idx_n = '0;
                    end
                end
            end
            ST_PUT: begin
                state_n   = ff_pend ? ST_CLEAR : ST_IDLE;
                clr_idx_n = '0;
            end
            ST_CLEAR: begin
                if (clr_idx < 7'(CHARS)) begin
                    we_n      = 1'b1;
                    addr_n    = clr_idx[5:0];
                    wdata_n   = fill;
                    clr_idx_n = clr_idx + 7'd1;
                end else begin
                    state_n  = ST_IDLE;
                    cursor_n = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            cursor    <= '0;
            fill      <= FILL_DEFAULT;
            clr_idx   <= '0;
            ff_pend   <= 1'b0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_n;
            cursor    <= cursor_n;
            fill      <= fill_n;
            clr_idx   <= clr_idx_n;
            ff_pend   <= ff_pend_n;
            buf_we    <= we_n;
            buf_addr  <= addr_n;
            buf_wdata <= wdata_n;
            if (rd_acc) begin
                cpu_rdata <= (off == OFF_STATUS) ? status : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Scoreboard bench for vga_console_ctrl: expected buf writes and load data are queued, a monitor compares.
module tb_vga_console_ctrl;

    localparam logic [63:0] BASE = 64'h0b000100;

    logic        clk;
    logic        aresetn;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic        cpu_ready;
    logic [63:0] cpu_rdata;
    logic        buf_we;
    logic [5:0]  buf_addr;
    logic [7:0]  buf_wdata;

    vga_console_ctrl #(
        .CHARS      (36),
        .COLS       (18),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
        int         exp_cyc;
        bit         consec;
    } wr_t;

    wr_t         wq[$];
    logic [63:0] rq[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: compares load data and every buffer write against the queues.
    initial begin : monitor
        bit  rd_req;
        int  last_we;
        wr_t e;
        rd_req  = 1'b0;
        last_we = -10;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rdata: got 0x%0h with nothing queued", cpu_rdata);
                end else begin
                    chk("cpu_rdata", cpu_rdata, rq.pop_front());
                end
            end
            rd_req = cpu_re && cpu_ready && aresetn;
            if (buf_we) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_buf_we: addr %0d data 0x%0h, expected no write", buf_addr, buf_wdata);
                end else begin
                    e = wq.pop_front();
                    chk("buf_addr", 64'(buf_addr), 64'(e.a));
                    chk("buf_wdata", 64'(buf_wdata), 64'(e.d));
                    if (e.exp_cyc >= 0) chk("put_latency", 64'(cyc), 64'(e.exp_cyc));
                    if (e.consec) chk("clear_consecutive", 64'(cyc), 64'(last_we + 1));
                end
                last_we = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Tasks start just after a rising edge and return just after one.
    task automatic wr(input logic [6:0] off, input logic [63:0] d, output int waited, output int acc);
        cpu_addr  = BASE + 64'(off);
        cpu_wdata = d;
        cpu_we    = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!cpu_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!cpu_ready) begin
            checks++; errors++;
            $display("FAIL write_timeout: cpu_ready 0 for offset 0x%0h, required 1", off);
        end
        @(posedge clk);
        #1;
        acc    = cyc;
        cpu_we = 1'b0;
    endtask

    task automatic put(input logic [7:0] c);
        int w, a;
        wr(7'h00, {56'd0, c}, w, a);
    endtask

    task automatic set_cursor(input logic [63:0] v);
        int w, a;
        wr(7'h08, v, w, a);
    endtask

    task automatic rd(input logic [6:0] off, input logic [63:0] exp);
        rq.push_back(exp);
        cpu_addr = BASE + 64'(off);
        cpu_re   = 1'b1;
        @(posedge clk);
        #1 cpu_re = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_status(input logic [5:0] cur, input logic [7:0] fill);
        rd(7'h18, (64'(fill) << 16) | (64'(cur) << 8));
    endtask

    task automatic pause(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_clear(input logic [7:0] fill);
        for (int k = 0; k < 36; k++) wq.push_back('{6'(k), fill, -1, (k > 0)});
    endtask

    initial begin : stim
        int w, a;
        int waits[6];
        aresetn   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", 64'(cpu_ready), 64'd1);
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("rst_buf_we", 64'(buf_we), 64'd0);
        chk("rst_buf_addr", 64'(buf_addr), 64'd0);
        chk("rst_buf_wdata", 64'(buf_wdata), 64'd0);
        @(posedge clk);
        #1 aresetn = 1'b1;
        pause(1);
        rd_status(6'd0, 8'h20);

        // Single putchar with latency check
        wr(7'h00, 64'h48, w, a);
        wq.push_back('{6'd0, 8'h48, a + 1, 1'b0});
        pause(6);
        rd_status(6'd1, 8'h20);

        // Cursor clamp, then wrap from the last cell
        set_cursor(64'd50);
        rd_status(6'd35, 8'h20);
        wq.push_back('{6'd35, 8'h41, -1, 1'b0});
        wq.push_back('{6'd0, 8'h42, -1, 1'b0});
        put(8'h41);
        put(8'h42);
        pause(8);
        rd_status(6'd1, 8'h20);

        // Newline: next row, then wrap past the last row; unknown code dropped
        set_cursor(64'd5);
        put(8'h0A);
        pause(6);
        rd_status(6'd18, 8'h20);
        set_cursor(64'd20);
        put(8'h0A);
        pause(6);
        rd_status(6'd0, 8'h20);
        set_cursor(64'd9);
        put(8'h01);
        pause(6);
        rd_status(6'd9, 8'h20);

        // Hardware clear with fill 0x2A; CURSOR write blocked until done
        exp_clear(8'h2A);
        wr(7'h10, 64'h2A01, w, a);
        wr(7'h08, 64'd7, w, a);
        chk("cursor_blocked_mid_clear", 64'(w > 0), 64'd1);
        chk("clear_done_before_cursor", 64'(wq.size()), 64'd0);
        pause(2);
        rd_status(6'd7, 8'h2A);

        // FIFO fill during a clear: 5th DATA write stalls, all land at 0..5
        exp_clear(8'h20);
        wr(7'h10, 64'h2001, w, a);
        for (int i = 0; i < 6; i++) begin
            wq.push_back('{6'(i), 8'(8'h61 + i), -1, 1'b0});
            wr(7'h00, 64'(8'h61 + i), waits[i], a);
        end
        for (int i = 0; i < 4; i++) chk("fifo_push_no_stall", 64'(waits[i]), 64'd0);
        chk("fifo_full_stall", 64'(waits[4] > 0), 64'd1);
        pause(20);
        rd_status(6'd6, 8'h20);

        // Backspace
        set_cursor(64'd3);
`ifdef VGA_CON_BACKSPACE_EN
        wq.push_back('{6'd2, 8'h20, -1, 1'b0});
`endif
        put(8'h08);
        pause(6);
`ifdef VGA_CON_BACKSPACE_EN
        rd_status(6'd2, 8'h20);
`else
        rd_status(6'd3, 8'h20);
`endif
        set_cursor(64'd0);
`ifdef VGA_CON_BACKSPACE_EN
        wq.push_back('{6'd0, 8'h20, -1, 1'b0});
`endif
        put(8'h08);
        pause(6);
        rd_status(6'd0, 8'h20);

        // Form feed through the FIFO triggers a clear and homes the cursor
        set_cursor(64'd10);
        exp_clear(8'h20);
        put(8'h0C);
        pause(50);
        rd_status(6'd0, 8'h20);

        // Out-of-window write ignored and never stalled; DATA/CTRL read as zero
        wr(7'h48, 64'd5, w, a);
        chk("outside_window_ready", 64'(w), 64'd0);
        rd_status(6'd0, 8'h20);
        rd(7'h00, 64'd0);
        rd(7'h10, 64'd0);

        pause(4);
        chk("scoreboard_drained", 64'(wq.size() + rq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
